// File: rtl/reg_writeback.sv
// In-order write-back queue feeding the register file write port, with per-operand pending-write flags.
// Optional forwarding outputs fwd1/fwd2 are built when REG_WRITEBACK_FORWARD_EN is defined.
module reg_writeback #(
   parameter int REG_BITS_SIZE = 5,
   parameter int INST_SIZE     = 32,
   parameter int DEPTH         = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [REG_BITS_SIZE-1:0]   in_rd,
   input  logic [INST_SIZE-1:0]       in_data,
   output logic                       wr_en,
   output logic [REG_BITS_SIZE-1:0]   wr_addr,
   output logic [INST_SIZE-1:0]       wr_data,
   input  logic                       wr_ack,
   input  logic [REG_BITS_SIZE-1:0]   rs1,
   input  logic [REG_BITS_SIZE-1:0]   rs2,
   output logic                       busy1,
   output logic                       busy2,
   output logic [$clog2(DEPTH+1)-1:0] count
`ifdef REG_WRITEBACK_FORWARD_EN
   ,
   output logic [INST_SIZE-1:0]       fwd1,
   output logic [INST_SIZE-1:0]       fwd2
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [REG_BITS_SIZE-1:0] rd_q   [DEPTH];
   logic [INST_SIZE-1:0]     data_q [DEPTH];
   logic [PTR_W-1:0]         head_q, head_d;
   logic [PTR_W-1:0]         tail_q, tail_d;
   logic [CNT_W-1:0]         count_q, count_d;
   logic                     enq, deq;

   assign in_ready = (count_q < CNT_W'(DEPTH));
   assign wr_en    = (count_q != '0);
   // Empty queue presents zeros rather than a stale slot.
   assign wr_addr  = wr_en ? rd_q[head_q]   : '0;
   assign wr_data  = wr_en ? data_q[head_q] : '0;
   assign count    = count_q;

   // r0 writes complete the handshake but are dropped.
   assign enq = in_valid && in_ready && (in_rd != '0);
   assign deq = wr_en && wr_ack;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (enq) tail_d = tail_q + 1'b1;
      if (deq) head_d = head_q + 1'b1;
      if (enq && !deq)      count_d = count_q + 1'b1;
      else if (deq && !enq) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         rd_q[tail_q]   <= in_rd;
         data_q[tail_q] <= in_data;
      end
   end

   // Scan occupied slots by age offset from the head.
   always_comb begin
      logic [PTR_W-1:0] idx;
      idx   = '0;
      busy1 = 1'b0;
      busy2 = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_q + PTR_W'(k);
         if (CNT_W'(k) < count_q) begin
            if (rs1 != '0 && rd_q[idx] == rs1) busy1 = 1'b1;
            if (rs2 != '0 && rd_q[idx] == rs2) busy2 = 1'b1;
         end
      end
   end

`ifdef REG_WRITEBACK_FORWARD_EN
   // Later (younger) matches overwrite earlier ones.
   always_comb begin
      logic [PTR_W-1:0] idx;
      idx  = '0;
      fwd1 = '0;
      fwd2 = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_q + PTR_W'(k);
         if (CNT_W'(k) < count_q) begin
            if (rs1 != '0 && rd_q[idx] == rs1) fwd1 = data_q[idx];
            if (rs2 != '0 && rd_q[idx] == rs2) fwd2 = data_q[idx];
         end
      end
   end
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Scoreboard bench for reg_writeback: accepted results queue up in order and are compared as the DUT drains them.
module tb_reg_writeback;

   localparam int RB = 5;
   localparam int IW = 32;
   localparam int DP = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [RB-1:0] in_rd;
   logic [IW-1:0] in_data;
   logic          wr_en;
   logic [RB-1:0] wr_addr;
   logic [IW-1:0] wr_data;
   logic          wr_ack;
   logic [RB-1:0] rs1, rs2;
   logic          busy1, busy2;
   logic [2:0]    count;
`ifdef REG_WRITEBACK_FORWARD_EN
   logic [IW-1:0] fwd1, fwd2;
`endif

   reg_writeback #(.REG_BITS_SIZE(RB), .INST_SIZE(IW), .DEPTH(DP)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_data(in_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
      .rs1(rs1), .rs2(rs2), .busy1(busy1), .busy2(busy2), .count(count)
`ifdef REG_WRITEBACK_FORWARD_EN
      , .fwd1(fwd1), .fwd2(fwd2)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [RB-1:0] addr;
      logic [IW-1:0] data;
   } entry_t;

   entry_t exp_q[$];
   int     n_cmp = 0;
   int     n_bad = 0;

   task automatic chk(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Expected busy / youngest-match value for one operand, from the scoreboard.
   function automatic logic model_busy(input logic [RB-1:0] rs);
      model_busy = 1'b0;
      if (rs != '0)
         foreach (exp_q[i]) if (exp_q[i].addr == rs) model_busy = 1'b1;
   endfunction

   function automatic logic [IW-1:0] model_fwd(input logic [RB-1:0] rs);
      model_fwd = '0;
      if (rs != '0)
         foreach (exp_q[i]) if (exp_q[i].addr == rs) model_fwd = exp_q[i].data;
   endfunction

   // Inputs are already set; check outputs, advance the model, then cross one clock edge.
   task automatic cycle();
      logic do_enq, do_deq;
      #1;
      chk("count",    {29'd0, count}, exp_q.size());
      chk("in_ready", {31'd0, in_ready}, (exp_q.size() < DP) ? 1 : 0);
      chk("wr_en",    {31'd0, wr_en},   (exp_q.size() != 0) ? 1 : 0);
      if (exp_q.size() != 0) begin
         chk("wr_addr", {27'd0, wr_addr}, {27'd0, exp_q[0].addr});
         chk("wr_data", wr_data, exp_q[0].data);
      end else begin
         chk("wr_addr_idle", {27'd0, wr_addr}, 0);
         chk("wr_data_idle", wr_data, 0);
      end
      chk("busy1", {31'd0, busy1}, {31'd0, model_busy(rs1)});
      chk("busy2", {31'd0, busy2}, {31'd0, model_busy(rs2)});
`ifdef REG_WRITEBACK_FORWARD_EN
      chk("fwd1", fwd1, model_fwd(rs1));
      chk("fwd2", fwd2, model_fwd(rs2));
`endif
      if (reset) begin
         exp_q.delete();
      end else begin
         do_deq = (exp_q.size() != 0) && wr_ack;
         do_enq = in_valid && (exp_q.size() < DP) && (in_rd != '0);
         if (do_deq) void'(exp_q.pop_front());
         if (do_enq) exp_q.push_back('{addr: in_rd, data: in_data});
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [RB-1:0] rd, input logic [IW-1:0] d, input logic ack);
      in_valid = v;
      in_rd    = rd;
      in_data  = d;
      wr_ack   = ack;
      cycle();
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_rd = '0; in_data = '0; wr_ack = 1'b0; rs1 = '0; rs2 = '0;
      @(posedge clk);
      @(negedge clk);
      cycle();
      reset = 1'b0;

      // Single result, acked immediately
      rs1 = 5'd3; rs2 = 5'd0;
      drive(1'b1, 5'd3, 32'h1234_5678, 1'b1);
      drive(1'b0, 5'd0, 32'h0, 1'b1);
      drive(1'b0, 5'd0, 32'h0, 1'b1);

      // Fill to DEPTH, fifth result refused, then drain in order
      rs1 = 5'd2; rs2 = 5'd4;
      for (int i = 1; i <= DP; i++) drive(1'b1, RB'(i), 32'hA000_0000 + i, 1'b0);
      drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0);
      for (int i = 0; i < DP + 1; i++) drive(1'b0, 5'd0, 32'h0, 1'b1);

      // r0 write is dropped
      drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
      drive(1'b0, 5'd0, 32'h0, 1'b0);

      // Two pending writes to r5
      rs1 = 5'd5; rs2 = 5'd6;
      drive(1'b1, 5'd5, 32'hA, 1'b0);
      drive(1'b1, 5'd5, 32'hB, 1'b0);
      drive(1'b0, 5'd0, 32'h0, 1'b0);
      drive(1'b0, 5'd0, 32'h0, 1'b1);
      drive(1'b0, 5'd0, 32'h0, 1'b1);
      drive(1'b0, 5'd0, 32'h0, 1'b0);

      // Simultaneous enqueue and dequeue at count=2
      rs1 = 5'd7; rs2 = 5'd9;
      drive(1'b1, 5'd7, 32'h7777, 1'b0);
      drive(1'b1, 5'd8, 32'h8888, 1'b0);
      drive(1'b1, 5'd9, 32'h9999, 1'b1);
      drive(1'b0, 5'd0, 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b0, 5'd0, 32'h0, 1'b1);

      // Reset with three entries queued
      rs1 = 5'd10; rs2 = 5'd11;
      drive(1'b1, 5'd10, 32'h10, 1'b0);
      drive(1'b1, 5'd11, 32'h11, 1'b0);
      drive(1'b1, 5'd12, 32'h12, 1'b0);
      reset = 1'b1;
      drive(1'b0, 5'd0, 32'h0, 1'b0);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) drive(1'b0, 5'd0, 32'h0, 1'b1);

      // Random traffic with small register range to provoke collisions
      for (int i = 0; i < 400; i++) begin
         rs1 = RB'($urandom_range(0, 7));
         rs2 = RB'($urandom_range(0, 7));
         drive(1'($urandom_range(0, 1)), RB'($urandom_range(0, 7)), $urandom(),
               ($urandom_range(0, 2) != 0));
      end
      for (int i = 0; i < DP + 1; i++) drive(1'b0, 5'd0, 32'h0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
